// File: rtl/seg7_scan_mux.sv
// Multiplexed N-digit 7-segment scan driver: per-scan frame snapshot, dead-time between digits,
// hex/decimal decode, per-digit blank and blink masks, registered polarity-adjusted pins.
//
// state | meaning
// DEAD  | cnt < BLANK_CYC: every select, segment and dp held inactive (anti-ghosting)
// DRIVE | cnt >= BLANK_CYC: select of digit idx active, segments from the shadow frame
module seg7_scan_mux #(
    parameter int N_DIGITS    = 8,
    parameter int SCAN_DIV    = 65536,
    parameter int BLANK_CYC   = 256,
    parameter int BLINK_DIV   = 2**24,
    parameter int HEX_MODE    = 0,
    parameter int SEG_ACT_LOW = 1,
    parameter int SEL_ACT_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [4*N_DIGITS-1:0]   digits_i,
    input  logic [N_DIGITS-1:0]     dp_i,
    input  logic [N_DIGITS-1:0]     blank_mask_i,
    input  logic [N_DIGITS-1:0]     blink_mask_i,
    input  logic                    blink_en,
    output logic [6:0]              seg_o,
    output logic                    dp_o,
    output logic [N_DIGITS-1:0]     sel_o,
    output logic                    frame_start_o
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int BW = $clog2(BLINK_DIV);

    // XOR masks that turn a logical-active 1 into the pin level
    localparam logic [6:0]          SEG_OFF = {7{SEG_ACT_LOW != 0}};
    localparam logic                DP_OFF  = (SEG_ACT_LOW != 0);
    localparam logic [N_DIGITS-1:0] SEL_OFF = {N_DIGITS{SEL_ACT_LOW != 0}};

    logic [CW-1:0]           cnt;
    logic [IW-1:0]           idx;
    logic [BW-1:0]           blink_cnt;
    logic                    blink_ph;
    logic [4*N_DIGITS-1:0]   sh_digits;
    logic [N_DIGITS-1:0]     sh_dp;
    logic [N_DIGITS-1:0]     sh_blank;
    logic [N_DIGITS-1:0]     sh_blink;
    logic                    load;
    logic                    drive;
    logic                    dark;
    logic [3:0]              code;
    logic [6:0]              seg_nx;
    logic                    dp_nx;
    logic [N_DIGITS-1:0]     sel_nx;

    function automatic logic [6:0] decode(input logic [3:0] c);
        logic [6:0] p;
        case (c)
            4'h0:    p = 7'h3f;
            4'h1:    p = 7'h06;
            4'h2:    p = 7'h5b;
            4'h3:    p = 7'h4f;
            4'h4:    p = 7'h66;
            4'h5:    p = 7'h6d;
            4'h6:    p = 7'h7d;
            4'h7:    p = 7'h07;
            4'h8:    p = 7'h7f;
            4'h9:    p = 7'h6f;
            4'ha:    p = (HEX_MODE != 0) ? 7'h77 : 7'h00;
            4'hb:    p = (HEX_MODE != 0) ? 7'h7c : 7'h00;
            4'hc:    p = (HEX_MODE != 0) ? 7'h39 : 7'h00;
            4'hd:    p = (HEX_MODE != 0) ? 7'h5e : 7'h00;
            4'he:    p = (HEX_MODE != 0) ? 7'h79 : 7'h00;
            default: p = (HEX_MODE != 0) ? 7'h71 : 7'h00;
        endcase
        return p;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt == CW'(SCAN_DIV - 1)) begin
            cnt <= '0;
            idx <= (idx == IW'(N_DIGITS - 1)) ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Blink phase timer: down-counter, toggles the phase at terminal count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt <= BW'(BLINK_DIV - 1);
            blink_ph  <= 1'b0;
        end else if (blink_cnt == '0) begin
            blink_cnt <= BW'(BLINK_DIV - 1);
            blink_ph  <= ~blink_ph;
        end else begin
            blink_cnt <= blink_cnt - 1'b1;
        end
    end

    assign load = (cnt == '0) && (idx == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_digits     <= '0;
            sh_dp         <= '0;
            sh_blank      <= '0;
            sh_blink      <= '0;
            frame_start_o <= 1'b0;
        end else begin
            frame_start_o <= load;
            if (load) begin
                sh_digits <= digits_i;
                sh_dp     <= dp_i;
                sh_blank  <= blank_mask_i;
                sh_blink  <= blink_mask_i;
            end
        end
    end

    always_comb begin
        drive  = (cnt >= CW'(BLANK_CYC));
        code   = sh_digits[4*idx +: 4];
        dark   = !en || sh_blank[idx] || (blink_en && sh_blink[idx] && blink_ph);
        sel_nx = '0;
        seg_nx = '0;
        dp_nx  = 1'b0;
        if (drive && en) begin
            sel_nx[idx] = 1'b1;
        end
        if (drive && !dark) begin
            seg_nx = decode(code);
            dp_nx  = sh_dp[idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_o <= SEG_OFF;
            dp_o  <= DP_OFF;
            sel_o <= SEL_OFF;
        end else begin
            seg_o <= seg_nx ^ SEG_OFF;
            dp_o  <= dp_nx ^ DP_OFF;
            sel_o <= sel_nx ^ SEL_OFF;
        end
    end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Scoreboard bench for seg7_scan_mux (4 digits, 8-cycle slots, 2 dead cycles, 64-cycle blink).
// Expected slots are queued per frame; a negedge monitor pops one entry per completed driven slot.
module tb_seg7_scan_mux;

    typedef struct packed {
        logic [3:0] sel;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b1;
    logic        blink_en = 1'b0;
    logic [15:0] digits_i = 16'h1234;
    logic [3:0]  dp_i = 4'h0;
    logic [3:0]  blank_mask_i = 4'h0;
    logic [3:0]  blink_mask_i = 4'h0;
    logic [6:0]  seg_o, hseg;
    logic        dp_o, hdp;
    logic [3:0]  sel_o, hsel;
    logic        frame_start_o, hfs;

    int   checks = 0;
    int   failures = 0;
    bit   mon_en = 1'b0;
    int   next_frame = 0;
    int   cur_frame = 0;
    int   sync_wait = 0;
    exp_t exp_q[$];

    seg7_scan_mux #(.N_DIGITS(4), .SCAN_DIV(8), .BLANK_CYC(2), .BLINK_DIV(64),
                    .HEX_MODE(0), .SEG_ACT_LOW(1), .SEL_ACT_LOW(1)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .digits_i(digits_i), .dp_i(dp_i),
        .blank_mask_i(blank_mask_i), .blink_mask_i(blink_mask_i), .blink_en(blink_en),
        .seg_o(seg_o), .dp_o(dp_o), .sel_o(sel_o), .frame_start_o(frame_start_o));

    seg7_scan_mux #(.N_DIGITS(4), .SCAN_DIV(8), .BLANK_CYC(2), .BLINK_DIV(64),
                    .HEX_MODE(1), .SEG_ACT_LOW(1), .SEL_ACT_LOW(1)) dut_hex (
        .clk(clk), .rst_n(rst_n), .en(en), .digits_i(digits_i), .dp_i(dp_i),
        .blank_mask_i(blank_mask_i), .blink_mask_i(blink_mask_i), .blink_en(blink_en),
        .seg_o(hseg), .dp_o(hdp), .sel_o(hsel), .frame_start_o(hfs));

    always #5 clk = ~clk;

    // Active-low decimal glyphs; codes 10-15 are dark without hex decoding
    function automatic logic [6:0] pat_al(input logic [3:0] c);
        case (c)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_frame(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] blank,
                              input logic [3:0] blink, input logic ben, input logic ph);
        exp_t e;
        logic dk;
        for (int k = 0; k < 4; k++) begin
            dk    = blank[k] | (ben & blink[k] & ph);
            e.sel = ~(4'b0001 << k);
            e.seg = dk ? 7'h7f : pat_al(d[4*k +: 4]);
            e.dp  = dk ? 1'b1 : ~dp[k];
            exp_q.push_back(e);
        end
    endtask

    task automatic sync_frame();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_start_o && n < 100);
        sync_wait = n;
        if (!frame_start_o) begin
            checks++;
            failures++;
            $display("FAIL sync_timeout: got no frame_start after %0d cycles expected a pulse", n);
        end
        cur_frame = next_frame;
        next_frame++;
    endtask

    // Blink half-period is two frames, both timers start together out of reset
    task automatic frame(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] blank,
                         input logic [3:0] blink, input logic ben);
        digits_i = d;
        dp_i = dp;
        blank_mask_i = blank;
        blink_mask_i = blink;
        sync_frame();
        blink_en = ben;
        push_frame(d, dp, blank, blink, ben, ((cur_frame >> 1) & 1) != 0);
        @(negedge clk);
        mon_en = 1'b1;
    endtask

    int         cyc = 0;
    int         last_fs = 0;
    bit         have_fs = 1'b0;
    bit         act = 1'b0;
    bit         stable = 1'b0;
    int         slot_len = 0;
    logic [3:0] rec_sel;
    logic [6:0] rec_seg;
    logic       rec_dp;
    exp_t       e_pop;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            have_fs = 1'b0;
            act = 1'b0;
        end else begin
            if (frame_start_o) begin
                if (have_fs) check("frame_period", cyc - last_fs, 32);
                have_fs = 1'b1;
                last_fs = cyc;
            end
            if (!mon_en) begin
                act = 1'b0;
            end else if (sel_o != 4'hf) begin
                if (!act) begin
                    act = 1'b1;
                    rec_sel = sel_o;
                    rec_seg = seg_o;
                    rec_dp = dp_o;
                    slot_len = 1;
                    stable = 1'b1;
                end else begin
                    slot_len++;
                    if (sel_o != rec_sel || seg_o != rec_seg || dp_o != rec_dp) stable = 1'b0;
                end
            end else if (act) begin
                act = 1'b0;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_slot: got sel %b seg %b with empty queue expected none", rec_sel, rec_seg);
                end else begin
                    e_pop = exp_q.pop_front();
                    check("slot", {15'd0, rec_sel, rec_seg, rec_dp, 4'(slot_len), stable},
                          {15'd0, e_pop.sel, e_pop.seg, e_pop.dp, 4'd6, 1'b1});
                end
            end
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        check("reset_sel", sel_o, 4'hf);
        check("reset_seg", seg_o, 7'h7f);
        check("reset_dp", dp_o, 1'b1);
        check("reset_fs", frame_start_o, 1'b0);
        rst_n = 1'b1;

        frame(16'h1234, 4'h0, 4'h0, 4'h0, 1'b0);
        frame(16'h1234, 4'h0, 4'h0, 4'h0, 1'b0);
        repeat (10) @(negedge clk);
        digits_i = 16'h5678;
        frame(16'h5678, 4'b0101, 4'h0, 4'h0, 1'b0);

        for (int f = 3; f <= 6; f++) frame(16'h1234, 4'h0, 4'h0, 4'b0011, 1'b1);

        sync_frame();
        @(negedge clk);
        mon_en = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("blink_dark_sel", sel_o, 4'he);
        check("blink_dark_seg", seg_o, 7'h7f);
        blink_en = 1'b0;
        @(negedge clk);
        check("blink_restore_seg", seg_o, 7'b0011001);

        frame(16'hfa09, 4'h0, 4'h0, 4'h0, 1'b0);
        repeat (17) @(negedge clk);
        check("hex_a_sel", hsel, 4'hb);
        check("hex_a_seg", hseg, 7'b0001000);
        repeat (8) @(negedge clk);
        check("hex_f_sel", hsel, 4'h7);
        check("hex_f_seg", hseg, 7'b0001110);

        frame(16'h1234, 4'h0, 4'b1000, 4'h0, 1'b0);
        mon_en = 1'b0;
        exp_q.delete();
        en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("en_off_sel", sel_o, 4'hf);
            check("en_off_seg", seg_o, 7'h7f);
            check("en_off_dp", dp_o, 1'b1);
        end
        en = 1'b1;
        frame(16'h1234, 4'h0, 4'h0, 4'h0, 1'b0);
        frame(16'h1234, 4'h0, 4'h0, 4'h0, 1'b0);

        mon_en = 1'b0;
        exp_q.delete();
        repeat (19) @(negedge clk);
        check("pre_reset_sel", sel_o, 4'hb);
        rst_n = 1'b0;
        #1;
        check("async_reset_sel", sel_o, 4'hf);
        check("async_reset_seg", seg_o, 7'h7f);
        check("async_reset_dp", dp_o, 1'b1);
        check("async_reset_fs", frame_start_o, 1'b0);
        digits_i = 16'h5678;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        next_frame = 0;
        frame(16'h5678, 4'h0, 4'h0, 4'h0, 1'b0);
        check("first_snapshot_wait", sync_wait, 1);
        frame(16'h5678, 4'h0, 4'h0, 4'h0, 1'b0);

        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
